// File: rtl/dma_pkg.sv
// Shared DMA definitions: address/length widths, FSM state encoding
// and the descriptor bundle used by dma_desc_queue and dma_controller.
package dma_pkg;

  localparam int ADDR_W = 4;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } dma_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
  } dma_desc_t;

endpackage

// File: rtl/dma_desc_fifo.sv
// Descriptor FIFO, DEPTH entries (power of 2, >= 2), sync active-high rst.
// Ports: push/din in, pop in, head out, full/empty/level status out.
module dma_desc_fifo
  import dma_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  dma_desc_t       din,
  input  logic            pop,
  output dma_desc_t       head,
  output logic            full,
  output logic            empty,
  output logic [LW-1:0]   level
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;
  dma_desc_t     mem_q [DEPTH];

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointers are log2(DEPTH) wide, so wrap is the natural overflow.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    cnt_d    = cnt_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/dma_desc_queue.sv
// Descriptor queue feeding a single-byte dma_controller (sync active-high rst).
// Ports: push_* host side, dma_start/src/dst/done controller side, busy, level.
// Optional: define DMA_DESC_IRQ_EN to add irq, a pulse after a final dma_done.
module dma_desc_queue
  import dma_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ADDR_W-1:0] push_src,
  input  logic [ADDR_W-1:0] push_dst,
  input  logic [LEN_W-1:0]  push_len,
  output logic              dma_start,
  output logic [ADDR_W-1:0] dma_src,
  output logic [ADDR_W-1:0] dma_dst,
  input  logic              dma_done,
  output logic              busy,
  output logic [LW-1:0]     level
`ifdef DMA_DESC_IRQ_EN
  ,
  output logic              irq
`endif
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              start_q, start_d;

  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  dma_desc_t push_desc;
  dma_desc_t head;

  assign push_desc = '{src: push_src, dst: push_dst, len: push_len};

  dma_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_valid),
    .din   (push_desc),
    .pop   (fifo_pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign push_ready = !fifo_full;
  assign busy       = (state_q != ST_IDLE);
  assign dma_start  = start_q;
  assign dma_src    = src_q;
  assign dma_dst    = dst_q;

  // dma_done only matters in WAIT; IDLE and ISSUE ignore it.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    start_d  = 1'b0;
    fifo_pop = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          src_d    = head.src;
          dst_d    = head.dst;
          rem_d    = head.len;
          state_d  = ST_ISSUE;
        end
      end
      (state_q == ST_ISSUE): begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      (state_q == ST_WAIT): begin
        if (dma_done) begin
          if (rem_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            src_d   = src_q + 1'b1;
            dst_d   = dst_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      start_q <= start_d;
    end
  end

`ifdef DMA_DESC_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (state_q == ST_WAIT) && dma_done && (rem_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: doc/dma_desc_queue.md
DMA_DESC_QUEUE -- requirements
Module: dma_desc_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of descriptor FIFO entries; SHALL be a power of 2 and at least 2.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 push_valid  input  1  host offers a descriptor this cycle.
REQ-005 push_ready  output  1  queue can accept a descriptor; SHALL equal not-full.
REQ-006 push_src  input  4  first source address of the descriptor.
REQ-007 push_dst  input  4  first destination address of the descriptor.
REQ-008 push_len  input  4  transfer count minus 1 (0 means 1 byte, 15 means 16 bytes).
REQ-009 dma_start  output  1  one-cycle start pulse to the downstream dma_controller.
REQ-010 dma_src  output  4  source address for the current single-byte transfer.
REQ-011 dma_dst  output  4  destination address for the current single-byte transfer.
REQ-012 dma_done  input  1  downstream single-byte transfer complete.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 level  output  $clog2(DEPTH+1)  number of queued descriptors, excluding the active one.

Function
REQ-015 A push SHALL be accepted on a rising edge when push_valid && push_ready.
REQ-016 The descriptor FIFO SHALL be first-in first-out; read and write pointers SHALL wrap modulo DEPTH.
REQ-017 A push and a pop in the same cycle SHALL leave level unchanged; this SHALL also hold when level == DEPTH-1.
REQ-018 A push while full SHALL be dropped and SHALL change no state.
REQ-019 The FSM SHALL have exactly the states IDLE, ISSUE and WAIT.
REQ-020 IDLE with level>0: the FSM SHALL pop the head into working registers (src, dst, remaining=len) and go to ISSUE.
REQ-021 ISSUE: the block SHALL assert dma_start for exactly one cycle, then go to WAIT.
REQ-022 WAIT with dma_done and remaining==0: the FSM SHALL go to IDLE.
REQ-023 WAIT with dma_done and remaining>0: src and dst SHALL each increment mod 16 (0xF wraps to 0x0), remaining SHALL decrement, and the FSM SHALL go to ISSUE.
REQ-024 dma_src and dma_dst SHALL be driven from the working registers and held stable from ISSUE until dma_done.
REQ-025 dma_done SHALL be ignored in IDLE and ISSUE.
REQ-026 Latency: a push accepted at edge N into an empty, idle block SHALL give dma_start high in the cycle following edge N+2.
REQ-027 Back-to-back descriptors: the next descriptor's dma_start SHALL follow the final dma_done of the previous one by exactly 2 cycles.

Reset
REQ-028 While rst is high at a rising edge, the block SHALL empty the FIFO and set state=IDLE, level=0, dma_start=0, dma_src=0, dma_dst=0, busy=0, and irq=0 when present.
REQ-029 Reset asserted mid-transfer SHALL abandon the active descriptor and all queued descriptors.
REQ-030 A dma_done arriving after reset SHALL be ignored.

Configuration
REQ-031 With macro DMA_DESC_IRQ_EN defined, output port irq (1 bit) SHALL exist and SHALL pulse high for one cycle in the cycle after a descriptor's final dma_done.
REQ-032 Without DMA_DESC_IRQ_EN, port irq and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package dma_pkg SHALL hold the address width (4), the length width (4) and the FSM state encoding, shared with dma_controller.
REQ-034 The FIFO SHALL be a sub-module dma_desc_fifo (parameter DEPTH; provides push, pop, head, full, empty, level); the FSM and working registers SHALL reside in dma_desc_queue.

Verification
REQ-035 Single descriptor: push src=5, dst=A, len=0 -> one dma_start with dma_src=5, dma_dst=A; busy drops 1 cycle after dma_done; irq pulses once when enabled.
REQ-036 Burst with wrap: push src=E, dst=F, len=2 -> three starts with (src,dst) = (E,F), (F,0), (0,1).
REQ-037 Full queue: issue 6 pushes during a long WAIT with DEPTH=4 -> push_ready low at level 4, 5th and 6th descriptors dropped, exactly 4 queued descriptors executed in order.
REQ-038 Simultaneous push and pop at level 3 -> level stays 3 and the new descriptor executes last.
REQ-039 Reset mid-transfer: assert rst in WAIT with 2 queued -> level=0, IDLE, and a later dma_done produces no dma_start.
REQ-040 Stray dma_done while IDLE -> no state change and no dma_start.
